// File: rtl/serial_tx_out.sv
`timescale 1ns/1ps
// serial_tx_out
// -----------------------------------------------------------------------------
// Parallel-to-serial output transmitter. Result words arrive through a
// valid/ready handshake, are queued in a small circular FIFO and are shifted
// out MSB-first on Dout. Frame_out pulses for one cycle with the first bit of
// each frame. Frames follow each other with no gap while the FIFO has data.
//
// Build option:
//   OUT_PARITY_EN - when defined, each frame carries a 17th bit after the LSB:
//                   the even-parity bit (XOR of the 16 data bits).
//
// Parameters:
//   DEPTH         FIFO depth in words (power of two, 2..16)
//
// Ports:
//   Sclk          in   serial bit clock, all state changes on its rising edge
//   reset_n       in   synchronous active-low reset
//   word_in       in   [15:0] word to transmit
//   word_valid    in   word_in is valid this cycle
//   word_ready    out  FIFO can accept a word (not full)
//   Dout          out  serial data, MSB first, 0 when idle
//   Frame_out     out  high while Dout carries the first bit (bit 15)
//   output_ready  out  high during every bit cycle of a frame
//   overflow      out  sticky: a push was attempted while full
// -----------------------------------------------------------------------------
module serial_tx_out #(
    parameter int DEPTH = 4
) (
    input  logic        Sclk,
    input  logic        reset_n,
    input  logic [15:0] word_in,
    input  logic        word_valid,
    output logic        word_ready,
    output logic        Dout,
    output logic        Frame_out,
    output logic        output_ready,
    output logic        overflow
);

    localparam int AW = $clog2(DEPTH);
`ifdef OUT_PARITY_EN
    localparam int NBITS = 17;
`else
    localparam int NBITS = 16;
`endif
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [4:0]  LAST_BIT = 5'(NBITS - 1);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       count_q;
    logic [NBITS-1:0]  shreg_q, shreg_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic              dout_q, frame_q, ordy_q, overflow_q;

    logic              full, empty, push, pop;
    logic [NBITS-1:0]  load_word;

    // word_ready depends only on the registered occupancy, so a pop in the
    // same cycle does not let a push into a full FIFO through.
    assign full       = (count_q == FULL_CNT);
    assign empty      = (count_q == '0);
    assign word_ready = !full;
    assign push       = word_valid && !full;

    // Head of the FIFO is read combinationally so the pop and the shifter
    // load happen on the same edge.
`ifdef OUT_PARITY_EN
    assign load_word = {mem_q[rd_ptr_q], ^mem_q[rd_ptr_q]};
`else
    assign load_word = mem_q[rd_ptr_q];
`endif

    // ---------------- FIFO storage and pointers ----------------
    always_ff @(posedge Sclk) begin
        if (reset_n && push) begin
            mem_q[wr_ptr_q] <= word_in;
        end
    end

    always_ff @(posedge Sclk) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            // Pointers are log2(DEPTH) wide and wrap naturally.
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (word_valid && full) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // ---------------- Shifter state machine ----------------
    always_ff @(posedge Sclk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        pop       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    shreg_d   = load_word;
                    bit_cnt_d = '0;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (bit_cnt_q == LAST_BIT) begin
                    // Reload straight from the FIFO so the next frame
                    // starts on the very next cycle.
                    bit_cnt_d = '0;
                    if (!empty) begin
                        pop     = 1'b1;
                        shreg_d = load_word;
                    end else begin
                        shreg_d = '0;
                        state_d = S_IDLE;
                    end
                end else begin
                    shreg_d   = {shreg_q[NBITS-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ---------------- Registered serial outputs ----------------
    // Outputs are registered from the shifter state, so they change only on
    // the rising edge and are stable where the receiver samples.
    always_ff @(posedge Sclk) begin
        if (!reset_n) begin
            dout_q  <= 1'b0;
            frame_q <= 1'b0;
            ordy_q  <= 1'b0;
        end else begin
            dout_q  <= (state_q == S_SHIFT) && shreg_q[NBITS-1];
            frame_q <= (state_q == S_SHIFT) && (bit_cnt_q == '0);
            ordy_q  <= (state_q == S_SHIFT);
        end
    end

    assign Dout         = dout_q;
    assign Frame_out    = frame_q;
    assign output_ready = ordy_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_serial_tx_out.sv
`timescale 1ns/1ps
// Directed testbench for serial_tx_out (DEPTH = 4).
module tb_serial_tx_out;

`ifdef OUT_PARITY_EN
    localparam int NBITS = 17;
`else
    localparam int NBITS = 16;
`endif

    logic        Sclk       = 1'b0;
    logic        reset_n    = 1'b0;
    logic [15:0] word_in    = '0;
    logic        word_valid = 1'b0;
    logic        word_ready;
    logic        Dout;
    logic        Frame_out;
    logic        output_ready;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;

    serial_tx_out #(.DEPTH(4)) dut (
        .Sclk         (Sclk),
        .reset_n      (reset_n),
        .word_in      (word_in),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .Dout         (Dout),
        .Frame_out    (Frame_out),
        .output_ready (output_ready),
        .overflow     (overflow)
    );

    always #5 Sclk = ~Sclk;

    // Frame receiver: collects completed frames at the falling edge.
    logic [15:0] rx_q [$];
    logic [15:0] rx_acc  = '0;
    int          rx_bits = 0;
    logic [16:0] rx_full;
    logic [15:0] rx_word;
    assign rx_full = {rx_acc, Dout};
`ifdef OUT_PARITY_EN
    assign rx_word = rx_full[16:1];
`else
    assign rx_word = rx_full[15:0];
`endif

    always @(negedge Sclk) begin
        if (reset_n !== 1'b1) begin
            rx_bits <= 0;
        end else if (output_ready === 1'b1) begin
            if (Frame_out === 1'b1) begin
                rx_acc  <= {15'b0, Dout};
                rx_bits <= 1;
            end else begin
                rx_acc  <= rx_full[15:0];
                rx_bits <= rx_bits + 1;
                if (rx_bits == NBITS - 1) begin
                    rx_q.push_back(rx_word);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for Frame_out, then check every bit of the frame.
    // max_wait = 0 demands the frame starts at the very next falling edge.
    task automatic recv_frame(input logic [15:0] w, input int max_wait, input string tag);
        int   waited;
        logic exp_bit;
        waited = 0;
        @(negedge Sclk);
        while (Frame_out !== 1'b1 && waited < max_wait) begin
            @(negedge Sclk);
            waited++;
        end
        check({tag, " start"}, 32'(Frame_out), 32'd1);
        for (int i = 0; i < NBITS; i++) begin
            if (i > 0) @(negedge Sclk);
            exp_bit = (i < 16) ? w[15 - i] : ^w;
            check($sformatf("%s dout%0d", tag, i), 32'(Dout), 32'(exp_bit));
            check($sformatf("%s ordy%0d", tag, i), 32'(output_ready), 32'd1);
            check($sformatf("%s frame%0d", tag, i), 32'(Frame_out), 32'(i == 0));
        end
        $display("frame %s word=%04h", tag, w);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [15:0] fw [6];
    int          base;
    logic        seen;

    initial begin
        // ---------- Reset with word_valid held high ----------
        reset_n    = 1'b0;
        word_valid = 1'b1;
        word_in    = 16'h1234;
        repeat (3) @(posedge Sclk);
        @(negedge Sclk);
        check("rst dout", 32'(Dout), 32'd0);
        check("rst frame", 32'(Frame_out), 32'd0);
        check("rst ordy", 32'(output_ready), 32'd0);
        check("rst wready", 32'(word_ready), 32'd1);
        check("rst ovf", 32'(overflow), 32'd0);
        @(posedge Sclk); #1;
        reset_n    = 1'b1;
        word_valid = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge Sclk);
            if (output_ready !== 1'b0) seen = 1'b1;
        end
        check("rst no frame", 32'(seen), 32'd0);
        check("rst rx empty", 32'(rx_q.size()), 32'd0);
        $display("reset test done");

        // ---------- Single word with latency ----------
        @(posedge Sclk); #1;
        word_in    = 16'hA5C3;
        word_valid = 1'b1;
        @(posedge Sclk); #1;          // push edge k
        word_valid = 1'b0;
        @(negedge Sclk);
        check("single lat1 ordy", 32'(output_ready), 32'd0);
        @(negedge Sclk);              // after pop edge k+1
        check("single lat2 ordy", 32'(output_ready), 32'd0);
        check("single lat2 frame", 32'(Frame_out), 32'd0);
        recv_frame(16'hA5C3, 0, "single");
        @(negedge Sclk);
        check("single idle ordy", 32'(output_ready), 32'd0);
        check("single idle frame", 32'(Frame_out), 32'd0);
        check("single idle dout", 32'(Dout), 32'd0);

        // ---------- Back-to-back ----------
        @(posedge Sclk); #1;
        word_valid = 1'b1;
        word_in    = 16'hFFFF;
        @(posedge Sclk); #1;
        word_in    = 16'h0001;
        @(posedge Sclk); #1;
        word_in    = 16'h8000;
        @(posedge Sclk); #1;
        word_valid = 1'b0;
        recv_frame(16'hFFFF, 0, "b2b0");
        recv_frame(16'h0001, 0, "b2b1");
        recv_frame(16'h8000, 0, "b2b2");
        @(negedge Sclk);
        check("b2b idle ordy", 32'(output_ready), 32'd0);
        check("b2b rx count", 32'(rx_q.size()), 32'd4);

        // ---------- Full / overflow ----------
        base = rx_q.size();
        fw[0] = 16'h1111; fw[1] = 16'h2222; fw[2] = 16'h3333;
        fw[3] = 16'h4444; fw[4] = 16'h5555; fw[5] = 16'h6666;
        for (int i = 0; i < 6; i++) begin
            @(posedge Sclk); #1;
            word_in    = fw[i];
            word_valid = 1'b1;
            @(negedge Sclk);
            check($sformatf("full wready%0d", i), 32'(word_ready), 32'(i < 5));
            check($sformatf("full ovf%0d", i), 32'(overflow), 32'd0);
        end
        @(posedge Sclk); #1;          // sixth push dropped here
        word_valid = 1'b0;
        @(negedge Sclk);
        check("full ovf set", 32'(overflow), 32'd1);
        check("full wready low", 32'(word_ready), 32'd0);
        repeat (6 * NBITS + 10) @(negedge Sclk);
        check("full frames", 32'(rx_q.size() - base), 32'd5);
        for (int j = 0; j < 5; j++) begin
            if (base + j < rx_q.size())
                check($sformatf("full word%0d", j), 32'(rx_q[base + j]), 32'(fw[j]));
        end
        check("full ovf sticky", 32'(overflow), 32'd1);
        check("full drained wready", 32'(word_ready), 32'd1);
        $display("full test done frames=%0d", rx_q.size() - base);

        // ---------- Reset mid-frame ----------
        @(posedge Sclk); #1;
        word_valid = 1'b1;
        word_in    = 16'h1234;
        @(posedge Sclk); #1;          // edge k
        word_in    = 16'hAAAA;
        @(posedge Sclk); #1;          // k+1, pop 1234
        word_in    = 16'hBBBB;
        @(posedge Sclk); #1;          // k+2
        word_valid = 1'b0;
        repeat (7) @(posedge Sclk);   // k+9: bit 7 on Dout
        @(negedge Sclk);
        check("midrst bit7 ordy", 32'(output_ready), 32'd1);
        check("midrst bit7 frame", 32'(Frame_out), 32'd0);
        check("midrst bit7 dout", 32'(Dout), 32'd0);
        base = rx_q.size();
        reset_n = 1'b0;
        @(negedge Sclk);
        check("midrst dout", 32'(Dout), 32'd0);
        check("midrst frame", 32'(Frame_out), 32'd0);
        check("midrst ordy", 32'(output_ready), 32'd0);
        check("midrst wready", 32'(word_ready), 32'd1);
        check("midrst ovf clr", 32'(overflow), 32'd0);
        @(posedge Sclk); #1;
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge Sclk);
            if (output_ready !== 1'b0) seen = 1'b1;
        end
        check("midrst no resume", 32'(seen), 32'd0);
        check("midrst rx none", 32'(rx_q.size() - base), 32'd0);
        $display("mid-frame reset test done");

        // ---------- Pointer wrap ----------
        base = rx_q.size();
        for (int i = 0; i < 10; i++) begin
            @(posedge Sclk); #1;
            word_in    = 16'(i);
            word_valid = 1'b1;
            @(posedge Sclk); #1;
            word_valid = 1'b0;
            recv_frame(16'(i), 4, $sformatf("wrap%0d", i));
        end
        @(negedge Sclk);
        check("wrap idle ordy", 32'(output_ready), 32'd0);
        check("wrap frames", 32'(rx_q.size() - base), 32'd10);
        for (int j = 0; j < 10; j++) begin
            if (base + j < rx_q.size())
                check($sformatf("wrap word%0d", j), 32'(rx_q[base + j]), 32'(j));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
